// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter driving the async FIFO write port
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4,
    localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int BW       = $clog2(MAX_BURST + 1)
) (
    input  logic               wclk,
    input  logic               wrst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic               fifo_wen,
    output logic [DW-1:0]      fifo_wdata,
    input  logic               fifo_wfull,
    output logic [IW-1:0]      grant_id,
    output logic               busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [BW-1:0] beat_cnt;

    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic          in_burst;
    logic          g_valid;
    logic          g_last;
    logic          xfer;
    logic          last_beat;
    logic [IW-1:0] next_ptr;

    // Scan downwards so the candidate closest to rr_ptr is the one that sticks.
    always_comb begin : rr_scan
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[IW'(idx)]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(idx);
            end
        end
    end

    assign in_burst  = (state == BURST);
    assign busy      = in_burst;
    assign g_valid   = req_valid[grant_id];
    assign g_last    = req_last[grant_id];
    assign fifo_wen  = in_burst & g_valid & ~fifo_wfull;
    assign xfer      = fifo_wen;
    assign last_beat = (beat_cnt == BW'(MAX_BURST - 1));
    assign next_ptr  = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);

    always_comb begin
        req_ready  = '0;
        fifo_wdata = '0;
        if (in_burst) begin
            req_ready[grant_id] = ~fifo_wfull;
            fifo_wdata          = req_data[int'(grant_id)*DW +: DW];
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_id <= sel_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (!g_valid) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        // last flag and burst limit on the same beat collapse into one exit
                        if (g_last || last_beat) begin
                            state  <= IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic               wclk;
    logic               wrst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               fifo_wen;
    logic [DW-1:0]      fifo_wdata;
    logic               fifo_wfull;
    logic [1:0]         grant_id;
    logic               busy;

    int errors = 0;
    int checks = 0;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(4)) dut (
        .wclk       (wclk),
        .wrst       (wrst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata),
        .fifo_wfull (fifo_wfull),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        req_valid  = '0;
        req_last   = '0;
        fifo_wfull = 1'b0;
        wrst       = 1'b1;
        tick();
        wrst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_wen"}, fifo_wen, 0);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_wdata"}, fifo_wdata, 0);
    endtask

    task automatic check_beat(input string tag, input int g, input logic [DW-1:0] d);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_gid"}, grant_id, g);
        check({tag, "_wen"}, fifo_wen, 1);
        check({tag, "_wdata"}, fifo_wdata, d);
        check({tag, "_ready"}, req_ready, 1 << g);
    endtask

    always @(negedge wclk) begin
        check("wen_while_full", fifo_wen & fifo_wfull, 0);
    end

    initial begin
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        fifo_wfull = 1'b0;
        wrst       = 1'b1;
        tick();
        tick();
        wrst = 1'b0;
        #1;
        check_idle("rst");
        check("rst_gid", grant_id, 0);
        check("rst_rr", dut.rr_ptr, 0);

        // single requester, three beats
        req_valid = 4'b0010;
        set_data(1, 8'hA1);
        #1;
        check_idle("s_req");
        tick();
        check_beat("s_b0", 1, 8'hA1);
        tick();
        set_data(1, 8'hA2);
        #1;
        check_beat("s_b1", 1, 8'hA2);
        tick();
        set_data(1, 8'hA3);
        req_last = 4'b0010;
        #1;
        check_beat("s_b2", 1, 8'hA3);
        tick();
        req_valid = '0;
        req_last  = '0;
        #1;
        check_idle("s_end");
        check("s_rr", dut.rr_ptr, 2);
        check("s_gid_hold", grant_id, 1);

        // round-robin with everyone valid
        do_reset();
        for (int i = 0; i < NREQ; i++) set_data(i, 8'hB0 + 8'(i));
        req_valid = 4'b1111;
        #1;
        check_idle("rr_start");
        begin
            int order [5] = '{0, 1, 2, 3, 0};
            for (int b = 0; b < 5; b++) begin
                for (int t = 0; t < 4; t++) begin
                    tick();
                    check_beat($sformatf("rr_g%0d_t%0d", b, t), order[b], 8'hB0 + 8'(order[b]));
                end
                tick();
                check_idle($sformatf("rr_bubble%0d", b));
            end
        end

        // full stall on requester 2's second beat
        do_reset();
        req_valid = 4'b0100;
        set_data(2, 8'hC0);
        tick();
        check_beat("fs_b0", 2, 8'hC0);
        tick();
        set_data(2, 8'hC1);
        fifo_wfull = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            check($sformatf("fs_ready%0d", s), req_ready, 0);
            check($sformatf("fs_wen%0d", s), fifo_wen, 0);
            check($sformatf("fs_cnt%0d", s), dut.beat_cnt, 1);
            check($sformatf("fs_gid%0d", s), grant_id, 2);
            check($sformatf("fs_busy%0d", s), busy, 1);
            tick();
        end
        fifo_wfull = 1'b0;
        #1;
        check_beat("fs_b1", 2, 8'hC1);
        tick();
        set_data(2, 8'hC2);
        #1;
        check_beat("fs_b2", 2, 8'hC2);
        tick();
        set_data(2, 8'hC3);
        #1;
        check_beat("fs_b3", 2, 8'hC3);
        tick();
        check_idle("fs_end");
        check("fs_cnt_end", dut.beat_cnt, 4);
        check("fs_rr", dut.rr_ptr, 3);

        // valid drop while requester 3 waits
        do_reset();
        req_valid = 4'b1001;
        set_data(0, 8'hD0);
        set_data(3, 8'hE0);
        #1;
        check_idle("vd_start");
        tick();
        check_beat("vd_b0", 0, 8'hD0);
        tick();
        check_beat("vd_b1", 0, 8'hD0);
        tick();
        req_valid = 4'b1000;
        #1;
        check("vd_drop_busy", busy, 1);
        check("vd_drop_wen", fifo_wen, 0);
        check("vd_drop_ready", req_ready, 4'b0001);
        tick();
        req_valid = 4'b1001;
        #1;
        check_idle("vd_exit");
        check("vd_rr", dut.rr_ptr, 1);
        tick();
        req_last = 4'b1000;
        #1;
        check_beat("vd_g3", 3, 8'hE0);
        tick();
        req_last = '0;
        #1;
        check_idle("vd_g3_end");
        check("vd_rr_wrap", dut.rr_ptr, 0);
        tick();
        check_beat("vd_g0_again", 0, 8'hD0);
        req_valid = '0;
        #1;
        check("vd_g0_drop_wen", fifo_wen, 0);
        tick();
        check_idle("vd_end");

        // reset in the middle of a burst
        do_reset();
        req_valid = 4'b0100;
        set_data(0, 8'h50);
        set_data(2, 8'h52);
        tick();
        check_beat("mr_b0", 2, 8'h52);
        tick();
        tick();
        req_valid = 4'b1111;
        wrst      = 1'b1;
        #1;
        check_beat("mr_b2", 2, 8'h52);
        tick();
        wrst = 1'b0;
        #1;
        check_idle("mr_after");
        check("mr_gid", grant_id, 0);
        check("mr_rr", dut.rr_ptr, 0);
        check("mr_cnt", dut.beat_cnt, 0);
        tick();
        check_beat("mr_regrant", 0, 8'h50);
        req_valid = '0;
        tick();
        check_idle("mr_end");

        // last flag coincides with the burst limit
        do_reset();
        req_valid = 4'b0010;
        for (int t = 0; t < 4; t++) begin
            tick();
            set_data(1, 8'hF0 + 8'(t));
            if (t == 3) req_last = 4'b0010;
            #1;
            check_beat($sformatf("ce_b%0d", t), 1, 8'hF0 + 8'(t));
        end
        tick();
        req_last  = '0;
        req_valid = 4'b0110;
        set_data(2, 8'h62);
        #1;
        check_idle("ce_exit");
        check("ce_rr", dut.rr_ptr, 2);
        check("ce_cnt", dut.beat_cnt, 4);
        tick();
        check_beat("ce_next", 2, 8'h62);
        req_valid = '0;
        tick();
        check_idle("ce_end");

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the asynchronous FIFO among NREQ requesters in the write clock domain. It grants one requester at a time for a bounded burst, forwards that requester's data onto the FIFO write port, and back-pressures it with the FIFO full flag. It sits directly in front of the FIFO write controller and drives its write enable.

## Interface
- NREQ, 4, number of requesters; must be at least 2.
- DW, 8, data width per requester.
- MAX_BURST, 4, maximum beats per grant; must be at least 1.

- wclk  in  1  write-domain clock; all logic is on its rising edge.
- wrst  in  1  reset: one clock; reset is synchronous and active-high.
- req_valid  in  NREQ  per-requester data valid.
- req_data  in  NREQ*DW  packed data; requester i occupies bits [i*DW +: DW].
- req_last  in  NREQ  per-requester last beat of a packet; sampled only on a transfer.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- fifo_wen  out  1  write enable to the FIFO write controller.
- fifo_wdata  out  DW  write data to the FIFO.
- fifo_wfull  in  1  FIFO full flag from the write controller.
- grant_id  out  clog2(NREQ)  index of the current or last granted requester.
- busy  out  1  high while in the BURST state.

## Operation
- There are two states, IDLE and BURST. The registered state holds: state, grant_id, rr_ptr (clog2(NREQ) bits), and beat_cnt (clog2(MAX_BURST+1) bits).
- **IDLE**
  - If any req_valid bit is high, select the first set bit scanning rr_ptr, rr_ptr+1, … modulo NREQ.
  - Register that index into grant_id, clear beat_cnt, and go to BURST.
  - If no req_valid bit is high, stay in IDLE.
- **BURST** (g = grant_id)
  - req_ready[g] = ~fifo_wfull; all other req_ready bits are 0.
  - fifo_wen = req_valid[g] & ~fifo_wfull.
  - fifo_wdata = req_data[g].
  - A transfer is req_valid[g] & req_ready[g]. Each transfer increments beat_cnt.
- **BURST exit to IDLE**: leave BURST at the clock edge ending any cycle with one of these conditions:
  - (a) a transfer with req_last[g] = 1;
  - (b) a transfer that makes beat_cnt equal MAX_BURST;
  - (c) req_valid[g] = 0, meaning the requester went idle.
  - On every exit, rr_ptr <= (g+1) mod NREQ.
- **Full stall**: while fifo_wfull = 1, there is no transfer, beat_cnt holds, and the grant is kept. Condition (c) still applies if valid drops.
- **IDLE outputs**: req_ready = 0, fifo_wen = 0, fifo_wdata = 0. grant_id keeps its last value.
- **Arithmetic**: rr_ptr and grant_id wrap modulo NREQ, so NREQ need not be a power of two. beat_cnt never exceeds MAX_BURST.
- **Simultaneous events**
  - If condition (a) and condition (b) hit on the same beat, there is a single exit.
  - fifo_wfull rising in the same cycle that a requester asserts valid gives no transfer.
  - A requester asserting valid while another holds the grant waits; it gets no ready until it is arbitrated.
- **Fairness**: after requester g is served, every other requester that is continuously valid is granted before g is granted again. The worst-case wait is (NREQ-1)*(MAX_BURST+1) cycles plus any full-stall cycles.
- **Reset**: at the first wclk edge with wrst = 1, the block resets synchronously regardless of state, and any in-progress burst is abandoned.
  - state = IDLE, grant_id = 0, rr_ptr = 0, beat_cnt = 0.
  - Outputs: busy = 0, req_ready = 0, fifo_wen = 0, fifo_wdata = 0.
- fifo_wen must never be high while fifo_wfull is high. The FIFO also gates writes, but the arbiter must not rely on that.

## Timing
- **Arbitration latency**: a request seen in IDLE in cycle N is granted from cycle N+1. The first transfer happens in N+1 if the FIFO is not full.
- **Outputs**: req_ready, fifo_wen and fifo_wdata are combinational from registered state and the inputs (req_valid, req_data, fifo_wfull). There is no registered data stage.
- **Bubble**: every burst exit costs exactly one IDLE cycle before the next grant.
  - Sustained throughput with all requesters busy is MAX_BURST/(MAX_BURST+1) beats per cycle.
- busy is asserted in the cycle after the grant decision and deasserted in the cycle after the exit edge.
- fifo_wfull is a registered flag from the write controller. Data written on the edge that makes the FIFO full is accepted. There is no other combinational path from fifo_wfull into the registered state.

## Test plan
- **Single requester**: reset, then req_valid = 4'b0010 with 3 beats 0xA1, 0xA2, 0xA3 (last on 0xA3).
  - The grant is issued one cycle after valid, with grant_id = 1.
  - fifo_wen pulses for 3 consecutive cycles with data A1, A2, A3, then IDLE.
  - rr_ptr = 2.
- **Round-robin**: hold req_valid = 4'b1111 with no req_last and MAX_BURST = 4.
  - The grant order is 0, 1, 2, 3, 0, each with exactly 4 transfers.
  - There is exactly one idle cycle between bursts.
- **Full stall**: during requester 2's 2nd beat, hold fifo_wfull = 1 for 5 cycles.
  - req_ready[2] = 0 and fifo_wen = 0 throughout the stall, beat_cnt holds at 1, and grant_id stays 2.
  - The burst resumes afterwards and completes with 4 beats total.
- **Valid drop**: requester 0 sends 2 beats, then deasserts valid while requester 3 is waiting.
  - The block exits to IDLE, then grants requester 3.
  - Requester 0's next grant comes only after requesters 1–3 are considered.
- **Mid-burst reset**: assert wrst for 1 cycle during the 3rd beat of a burst.
  - After the following edge: busy = 0, req_ready = 0, fifo_wen = 0, grant_id = 0, rr_ptr = 0.
  - The next request with all valid is granted to requester 0.
- **Coincident exit**: MAX_BURST = 4 with req_last on the 4th beat.
  - This gives a single exit and a single rr_ptr advance.
  - Also check on every cycle that fifo_wen & fifo_wfull is never 1.
